// File: rtl/cache_line_ram.sv
// Line-organised cache data RAM with per-word enables, write-first reads and a burst line-fill engine.
// Optional per-word even parity is enabled by defining CACHE_LINE_RAM_PARITY_EN.
module cache_line_ram #(
  parameter int NL  = 128,
  parameter int LSS = 7,
  parameter int WW  = 32,
  parameter int WPL = 8,
  localparam int LW = WW * WPL
) (
  input  logic           nGCLK,
  input  logic           nRESET,
  input  logic           rd_en,
  input  logic [LSS-1:0] read_sel,
  output logic [LW-1:0]  read_port,
  output logic           rd_valid,
  input  logic           wr_ena,
  input  logic [LSS-1:0] write_sel,
  input  logic [WPL-1:0] word_be,
  input  logic [LW-1:0]  write_port,
  input  logic           fill_start,
  input  logic [LSS-1:0] fill_sel,
  input  logic [WW-1:0]  fill_data,
  input  logic           fill_valid,
  output logic           fill_ready,
  output logic           fill_busy,
  output logic           fill_done,
  output logic           par_err
);

  localparam int CW = (WPL > 1) ? $clog2(WPL) : 1;

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  state_t         state;
  logic [LSS-1:0] fsel;
  logic [CW-1:0]  cnt;
  logic [WPL-1:0] mask;
  logic [LW-1:0]  fbuf;

  logic [LW-1:0]  mem [NL];

  logic           cpu_wr;
  logic           commit_go;
  logic           arr_we;
  logic [LSS-1:0] arr_sel;
  logic [WPL-1:0] arr_be;
  logic [LW-1:0]  arr_data;
  logic [LW-1:0]  rd_line;
  logic [LW-1:0]  rd_next;
  logic           rd_fwd;

  assign fill_ready = (state == FILL);
  assign fill_busy  = (state != IDLE);
  assign fill_done  = commit_go;

  // Single array write port: a CPU store to another line stalls the commit by a cycle.
  always_comb begin
    cpu_wr    = wr_ena && (word_be != '0);
    commit_go = (state == COMMIT) && (!cpu_wr || (write_sel == fsel));
    arr_we    = 1'b0;
    arr_sel   = write_sel;
    arr_be    = word_be;
    arr_data  = write_port;
    if (cpu_wr) begin
      arr_we = 1'b1;
      if (commit_go) begin
        arr_be = word_be | ~mask;
        for (int i = 0; i < WPL; i++)
          if (!word_be[i]) arr_data[i*WW +: WW] = fbuf[i*WW +: WW];
      end
    end else if (state == COMMIT) begin
      arr_we   = 1'b1;
      arr_sel  = fsel;
      arr_be   = ~mask;
      arr_data = fbuf;
    end
  end

  always_comb begin
    rd_line = mem[read_sel];
    rd_fwd  = arr_we && (arr_sel == read_sel);
    rd_next = rd_line;
    for (int i = 0; i < WPL; i++)
      if (rd_fwd && arr_be[i]) rd_next[i*WW +: WW] = arr_data[i*WW +: WW];
  end

  always_ff @(posedge nGCLK) begin
    if (arr_we)
      for (int i = 0; i < WPL; i++)
        if (arr_be[i]) mem[arr_sel][i*WW +: WW] <= arr_data[i*WW +: WW];
  end

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      read_port <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) read_port <= rd_next;
    end
  end

  // The mask records words stored by the CPU mid-fill so the commit leaves them alone.
  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      state <= IDLE;
      fsel  <= '0;
      cnt   <= '0;
      mask  <= '0;
      fbuf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fill_start) begin
            fsel  <= fill_sel;
            cnt   <= '0;
            mask  <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          if (cpu_wr && (write_sel == fsel)) mask <= mask | word_be;
          if (fill_valid) begin
            fbuf[cnt*WW +: WW] <= fill_data;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WPL - 1)) state <= COMMIT;
          end
        end
        COMMIT: begin
          if (commit_go) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_LINE_RAM_PARITY_EN
  function automatic logic [WPL-1:0] word_par(input logic [LW-1:0] d);
    logic [WPL-1:0] p;
    for (int i = 0; i < WPL; i++) p[i] = ^d[i*WW +: WW];
    return p;
  endfunction

  logic [WPL-1:0] pmem [NL];
  logic [WPL-1:0] wr_par;
  logic [WPL-1:0] rd_par_st;

  assign wr_par = word_par(arr_data);

  always_ff @(posedge nGCLK) begin
    if (arr_we)
      for (int i = 0; i < WPL; i++)
        if (arr_be[i]) pmem[arr_sel][i] <= wr_par[i];
  end

  // Forwarded words carry freshly generated parity, matching the forwarded data.
  always_comb begin
    rd_par_st = pmem[read_sel];
    for (int i = 0; i < WPL; i++)
      if (rd_fwd && arr_be[i]) rd_par_st[i] = wr_par[i];
  end

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) par_err <= 1'b0;
    else         par_err <= rd_en && (word_par(rd_next) != rd_par_st);
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_line_ram.sv
// Scoreboard bench for cache_line_ram: directed stores, forwarding, fills, commit stall and reset mid-fill.
module tb_cache_line_ram;

  logic         nGCLK;
  logic         nRESET;
  logic         rd_en;
  logic [6:0]   read_sel;
  logic [255:0] read_port;
  logic         rd_valid;
  logic         wr_ena;
  logic [6:0]   write_sel;
  logic [7:0]   word_be;
  logic [255:0] write_port;
  logic         fill_start;
  logic [6:0]   fill_sel;
  logic [31:0]  fill_data;
  logic         fill_valid;
  logic         fill_ready;
  logic         fill_busy;
  logic         fill_done;
  logic         par_err;

  cache_line_ram dut (
    .nGCLK(nGCLK), .nRESET(nRESET),
    .rd_en(rd_en), .read_sel(read_sel), .read_port(read_port), .rd_valid(rd_valid),
    .wr_ena(wr_ena), .write_sel(write_sel), .word_be(word_be), .write_port(write_port),
    .fill_start(fill_start), .fill_sel(fill_sel), .fill_data(fill_data), .fill_valid(fill_valid),
    .fill_ready(fill_ready), .fill_busy(fill_busy), .fill_done(fill_done), .par_err(par_err)
  );

  initial nGCLK = 1'b0;
  always #5 nGCLK = ~nGCLK;

  typedef struct {
    string        name;
    logic [255:0] act;
    logic [255:0] exp;
  } chk_t;

  chk_t         chk_q[$];
  logic [255:0] rd_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         done_flag = 1'b0;
  logic [255:0] last_rd = '0;
  logic [255:0] exp_rd;
  chk_t         c;

  function automatic logic [255:0] seq(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = base + step * 32'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge nGCLK);
    #1;
  endtask

  task automatic push_chk(input string n, input logic [255:0] a, input logic [255:0] e);
    chk_t k;
    k.name = n;
    k.act  = a;
    k.exp  = e;
    chk_q.push_back(k);
  endtask

  task automatic sample_fill(input string n, input logic r, input logic b, input logic d);
    @(negedge nGCLK);
    push_chk({n, "_ready"}, {255'd0, fill_ready}, {255'd0, r});
    push_chk({n, "_busy"},  {255'd0, fill_busy},  {255'd0, b});
    push_chk({n, "_done"},  {255'd0, fill_done},  {255'd0, d});
  endtask

  task automatic do_read(input logic [6:0] sel, input logic [255:0] e);
    rd_en    = 1'b1;
    read_sel = sel;
    rd_q.push_back(e);
    tick();
    rd_en = 1'b0;
    tick();
  endtask

  // Monitor: drains directed checks and scores every read response against the queue.
  always @(negedge nGCLK) begin
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", c.name, c.act, c.exp);
      end
    end
    if (!nRESET) begin
      last_rd = '0;
    end else if (rd_valid) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got rd_valid=1 expected no read pending");
      end else begin
        exp_rd = rd_q.pop_front();
        if (read_port !== exp_rd) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", read_port, exp_rd);
        end
      end
      checks++;
      if (par_err !== 1'b0) begin
        errors++;
        $display("FAIL par_err: got %b expected 0", par_err);
      end
      last_rd = read_port;
    end else begin
      checks++;
      if (read_port !== last_rd) begin
        errors++;
        $display("FAIL rd_hold: got %h expected %h", read_port, last_rd);
      end
    end
    if (done_flag) begin
      checks++;
      if (rd_q.size() != 0) begin
        errors++;
        $display("FAIL rd_missing: got %0d outstanding expected 0", rd_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] l3, e3, l4, l5, la, lb, lc, wp, ea9;
    l5 = seq(32'h11111111, 32'h11111111);
    l3 = seq(32'h30000000, 32'h00000001);
    l4 = seq(32'h40404040, 32'h01010101);
    la = seq(32'h000000A0, 32'h00000001);
    lc = seq(32'h000000C0, 32'h00000001);

    nRESET = 1'b0; rd_en = 1'b0; read_sel = '0; wr_ena = 1'b0; write_sel = '0;
    word_be = '0; write_port = '0; fill_start = 1'b0; fill_sel = '0;
    fill_data = '0; fill_valid = 1'b0;
    repeat (3) tick();
    push_chk("rst_read_port", read_port, '0);
    push_chk("rst_rd_valid", {255'd0, rd_valid}, '0);
    push_chk("rst_fill_ready", {255'd0, fill_ready}, '0);
    push_chk("rst_fill_busy", {255'd0, fill_busy}, '0);
    push_chk("rst_fill_done", {255'd0, fill_done}, '0);
    push_chk("rst_par_err", {255'd0, par_err}, '0);
    nRESET = 1'b1;
    tick();

    // Full-line store then read; the idle cycle after it exercises read_port hold.
    wr_ena = 1'b1; write_sel = 7'd5; word_be = 8'hFF; write_port = l5;
    tick();
    wr_ena = 1'b0;
    do_read(7'd5, l5);

    // Zero byte-enable store must not change the line.
    wr_ena = 1'b1; write_sel = 7'd5; word_be = 8'h00; write_port = '1;
    tick();
    wr_ena = 1'b0;
    do_read(7'd5, l5);

    // Write-first forwarding of a single word.
    wr_ena = 1'b1; write_sel = 7'd3; word_be = 8'hFF; write_port = l3;
    tick();
    wp = '1; wp[64 +: 32] = 32'hDEADBEEF;
    e3 = l3; e3[64 +: 32] = 32'hDEADBEEF;
    wr_ena = 1'b1; write_sel = 7'd3; word_be = 8'h04; write_port = wp;
    rd_en = 1'b1; read_sel = 7'd3; rd_q.push_back(e3);
    tick();
    wr_ena = 1'b0; rd_en = 1'b0;
    tick();
    do_read(7'd3, e3);

    // Fill A: line 9, two stall cycles before word 3.
    fill_start = 1'b1; fill_sel = 7'd9;
    tick();
    fill_start = 1'b0;
    sample_fill("fa_start", 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        fill_valid = 1'b0;
        tick(); sample_fill("fa_stall", 1'b1, 1'b1, 1'b0);
        tick(); sample_fill("fa_stall", 1'b1, 1'b1, 1'b0);
      end
      fill_valid = 1'b1; fill_data = 32'h000000A0 + 32'(k);
      tick();
      fill_valid = 1'b0;
      if (k < 7) sample_fill("fa_word", 1'b1, 1'b1, 1'b0);
      else       sample_fill("fa_commit", 1'b0, 1'b1, 1'b1);
    end
    tick();
    sample_fill("fa_idle", 1'b0, 1'b0, 1'b0);
    do_read(7'd9, la);

    // Fill B: CPU store to word 1 lands before fill word 1; mid-fill read sees the array.
    lb = seq(32'h000000B0, 32'h00000001);
    lb[32 +: 32] = 32'h12345678;
    ea9 = la; ea9[32 +: 32] = 32'h12345678;
    wp = '1; wp[32 +: 32] = 32'h12345678;
    fill_start = 1'b1; fill_sel = 7'd9;
    tick();
    fill_start = 1'b0;
    write_sel = 7'd9; word_be = 8'h02; write_port = wp; read_sel = 7'd9;
    for (int k = 0; k < 8; k++) begin
      fill_valid = 1'b1; fill_data = 32'h000000B0 + 32'(k);
      wr_ena = (k == 0);
      rd_en  = (k == 3);
      if (k == 3) rd_q.push_back(ea9);
      tick();
    end
    wr_ena = 1'b0; rd_en = 1'b0; fill_valid = 1'b0;
    tick();
    do_read(7'd9, lb);

    // Fill C: CPU store to line 4 during COMMIT stalls the commit one cycle.
    fill_start = 1'b1; fill_sel = 7'd9;
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      fill_valid = 1'b1; fill_data = 32'h000000C0 + 32'(k);
      tick();
    end
    fill_valid = 1'b0;
    wr_ena = 1'b1; write_sel = 7'd4; word_be = 8'hFF; write_port = l4;
    sample_fill("fc_commit_hold", 1'b0, 1'b1, 1'b0);
    tick();
    wr_ena = 1'b0;
    sample_fill("fc_commit", 1'b0, 1'b1, 1'b1);
    tick();
    sample_fill("fc_idle", 1'b0, 1'b0, 1'b0);
    do_read(7'd4, l4);
    do_read(7'd9, lc);

    // Reset after three fill words: fill discarded, line 9 untouched.
    fill_start = 1'b1; fill_sel = 7'd9;
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fill_valid = 1'b1; fill_data = 32'h000000D0 + 32'(k);
      tick();
    end
    fill_valid = 1'b0;
    nRESET = 1'b0;
    #1;
    push_chk("rstmid_busy", {255'd0, fill_busy}, '0);
    push_chk("rstmid_ready", {255'd0, fill_ready}, '0);
    tick();
    nRESET = 1'b1;
    tick();
    sample_fill("rstmid_idle", 1'b0, 1'b0, 1'b0);
    do_read(7'd9, lc);

    done_flag = 1'b1;
    repeat (4) tick();
    $display("FAIL monitor_end: got no summary expected summary");
    $fatal(1, "monitor did not finish");
  end

endmodule
